bus_buffer_arbiter: RTL and testbench
=====================================

Name: bus_buffer_arbiter

Overview:
Round-robin arbiter that shares one tri-state bus buffer stage between N requesters.
- Grants the buffer to exactly one requester at a time and drives the buffer output enable.
- Enforces a one-cycle turnaround, with the buffer disabled, between owners so two drivers never contend on the bus.
- Caps ownership at MAX_HOLD cycles so no requester starves the others.

Parameters:
N, 4, number of requesters (2..16)
IDW, 2, width of owner index; must equal clog2(N)
MAX_HOLD, 16, maximum consecutive grant cycles per ownership (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  N  level request per requester; held high while the requester wants the bus
gnt  output  N  one-hot grant (registered); all zero when no owner
buf_en  output  1  enable for the shared buffer (registered); high only while a grant is active
owner  output  IDW  index of current or most recent owner
busy  output  1  high in GRANT and TURN states
timeout  output  1  one-cycle pulse when a grant is revoked because MAX_HOLD was reached

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0, buf_en=0, owner=0, busy=0, timeout=0.
  - state=IDLE, priority pointer ptr=0, hold counter=0.
  - Takes effect immediately, including mid-grant: buf_en drops without waiting for a clock edge.
- Arbitration: winner is the first set bit of req searching ptr, ptr+1, ... N-1, 0, ... ptr-1.
- States:
  - IDLE:
    - All outputs low except owner, which holds.
    - Any req set at edge k -> GRANT after edge k, with gnt=onehot(winner), buf_en=1, owner=winner, busy=1, hold counter=1.
    - Latency is one edge from request to grant.
  - GRANT:
    - gnt and buf_en stay stable. req bits of non-owners are ignored.
    - req[owner]=0 at an edge -> TURN after that edge.
    - hold counter==MAX_HOLD with req[owner] still 1 -> TURN after that edge, timeout=1 for exactly that following cycle.
    - Otherwise the hold counter increments.
    - On either exit: ptr=(owner+1) mod N.
  - TURN:
    - Lasts exactly one cycle: gnt=0, buf_en=0, busy=1, timeout as above.
    - At the next edge, if any req is set (arbitrated with the updated ptr) -> GRANT with the new winner, hold counter=1; else -> IDLE.
- Invariants:
  - gnt is always zero or one-hot.
  - buf_en == |gnt at all times.
  - Minimum gap between two consecutive grants is one cycle with buf_en=0.
- Boundary conditions:
  - Owner drops req in the same cycle another requester raises its req: handled by the normal TURN path; no grant is lost.
  - Timed-out requester still requesting: re-granted only if no other requester is set when TURN ends. If it is the sole requester, it gets GRANT after one TURN cycle.
  - MAX_HOLD=1: every grant lasts one cycle, then TURN.
  - ptr wraps from N-1 to 0.
  - req glitching on non-owners has no effect during GRANT.
  - The hold counter must be wide enough for MAX_HOLD without overflow.

Test Plan:
1. Reset, then req=4'b0000 for 5 cycles -> gnt=0, buf_en=0, busy=0, owner=0 throughout.
2. req=4'b0100 held 3 cycles then 0 -> gnt=4'b0100 and buf_en=1 for 3 cycles starting one edge after req rises; owner=2; one TURN cycle with busy=1, gnt=0; then IDLE, with ptr=3 checked by the next arbitration.
3. After reset, req=4'b1111 held constantly, MAX_HOLD=16 -> grants in order 0,1,2,3,0, each exactly 16 cycles; a 1-cycle gap with buf_en=0 between them; timeout pulses once per revocation.
4. Owner 1 releases req in the same cycle req[3] rises (req: 4'b0010 -> 4'b1000) -> TURN for 1 cycle, then gnt=4'b1000; no cycle ever has two gnt bits set.
5. Sole requester 0 held for 40 cycles, MAX_HOLD=16 -> grant 16 cycles, TURN, grant 16 cycles, TURN, grant for the remaining cycles; timeout pulses twice.
6. rst_n asserted low mid-grant (gnt=4'b0010) between clock edges -> gnt, buf_en and busy go 0 immediately. After release with req=4'b0010 still held, the grant returns one edge later with owner=1 (ptr reset to 0, req0 clear).

Source files
------------

// File: rtl/bus_buffer_arbiter.sv
// rtl/bus_buffer_arbiter.sv - round-robin owner arbitration for a shared tri-state bus buffer
module bus_buffer_arbiter #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   gnt,
    output logic           buf_en,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           timeout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_nxt;
    logic [IDW-1:0] owner_nxt;
    logic [IDW-1:0] owner_inc;
    logic [IDW-1:0] win;
    logic           win_vld;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_nxt;
    logic [N-1:0]   gnt_nxt;
    logic           timeout_nxt;
    logic [2*N-1:0] req_rot;
    logic [IDW:0]   win_sum;

    // Rotate requests so bit 0 is the requester at ptr; the lowest set bit wins.
    assign req_rot = {req, req} >> ptr;

    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        win_sum = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_sum = {1'b0, ptr} + (IDW + 1)'(i);
                if (win_sum >= (IDW + 1)'(N)) begin
                    win_sum = win_sum - (IDW + 1)'(N);
                end
                win     = win_sum[IDW-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign owner_inc = (owner == IDW'(N - 1)) ? '0 : owner + IDW'(1);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        hold_nxt    = hold_cnt;
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        timeout_nxt = 1'b0;
        case (state)
            IDLE, TURN: begin
                gnt_nxt = '0;
                if (win_vld) begin
                    state_nxt = GRANT;
                    gnt_nxt   = N'(1) << win;
                    owner_nxt = win;
                    hold_nxt  = HW'(1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            GRANT: begin
                if (!req[owner] || hold_cnt == HW'(MAX_HOLD)) begin
                    state_nxt   = TURN;
                    gnt_nxt     = '0;
                    ptr_nxt     = owner_inc;
                    timeout_nxt = req[owner];
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            buf_en   <= 1'b0;
            owner    <= '0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            gnt      <= gnt_nxt;
            buf_en   <= |gnt_nxt;
            owner    <= owner_nxt;
            timeout  <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_bus_buffer_arbiter.sv
// tb/tb_bus_buffer_arbiter.sv - scoreboard bench for bus_buffer_arbiter
module tb_bus_buffer_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       buf_en;
    logic [1:0] owner;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;
    int tcount   = 0;
    int viol     = 0;
    int cur_len  = 0;
    logic [3:0] cur_gnt = '0;
    int obs_q[$];
    int exp_q[$];

    bus_buffer_arbiter #(.N(4), .IDW(2), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .buf_en  (buf_en),
        .owner   (owner),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    function automatic int burst_code(logic [3:0] g, int len);
        int idx;
        idx = -1;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        return idx * 1000 + len;
    endfunction

    // Collects completed grant bursts as owner*1000+length and counts invariant breaks.
    always @(negedge clk) begin
        if (!rst_n) begin
            cur_len = 0;
        end else begin
            if (timeout) tcount++;
            if (buf_en !== (|gnt) || $countones(gnt) > 1) viol++;
            if (gnt != 4'b0000) begin
                if (cur_len == 0) begin
                    cur_gnt = gnt;
                    cur_len = 1;
                end else if (gnt == cur_gnt) begin
                    cur_len++;
                end else begin
                    viol++;
                    obs_q.push_back(burst_code(cur_gnt, cur_len));
                    cur_gnt = gnt;
                    cur_len = 1;
                end
            end else if (cur_len > 0) begin
                obs_q.push_back(burst_code(cur_gnt, cur_len));
                cur_len = 0;
            end
        end
    end

    task automatic do_reset();
        req = 4'b0000;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        checks++;
        if ({gnt, buf_en, busy, owner, timeout} !== 9'd0) begin
            failures++;
            $display("FAIL reset_async gnt=%b buf_en=%b busy=%b owner=%0d timeout=%b, want all 0",
                     gnt, buf_en, busy, owner, timeout);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #2;
            checks++;
            if ({gnt, buf_en, busy, owner, timeout} !== 9'd0) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d gnt=%b buf_en=%b busy=%b owner=%0d, want all 0",
                         c, gnt, buf_en, busy, owner);
            end
        end
    endtask

    task automatic test_single_owner();
        int e;
        int o;
        req = 4'b0100;
        exp_q.push_back(2003);
        exp_q.push_back(3001);
        @(posedge clk);
        #2;
        checks++;
        if (gnt !== 4'b0100 || buf_en !== 1'b1 || owner !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant gnt=%b buf_en=%b owner=%0d busy=%b, want 0100 1 2 1", gnt, buf_en, owner, busy);
        end
        repeat (2) @(posedge clk);
        #2 req = 4'b0000;
        @(posedge clk);
        #2;
        checks++;
        if (gnt !== 4'b0000 || buf_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_turn gnt=%b buf_en=%b busy=%b, want 0000 0 1", gnt, buf_en, busy);
        end
        @(posedge clk);
        #2;
        checks++;
        if (busy !== 1'b0 || owner !== 2'd2) begin
            failures++;
            $display("FAIL single_idle busy=%b owner=%0d, want 0 2", busy, owner);
        end
        req = 4'b1111;
        @(posedge clk);
        #2 req = 4'b0000;
        checks++;
        if (owner !== 2'd3 || gnt !== 4'b1000) begin
            failures++;
            $display("FAIL single_ptr owner=%0d gnt=%b, want 3 1000", owner, gnt);
        end
        repeat (3) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL single_burst observed=%0d expected=%0d", o, e);
            end
        end
    endtask

    task automatic test_round_robin();
        int e;
        int o;
        int t0;
        do_reset();
        t0 = tcount;
        for (int k = 0; k < 5; k++) exp_q.push_back((k % 4) * 1000 + 16);
        req = 4'b1111;
        repeat (85) @(posedge clk);
        #2 req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL rr_burst observed=%0d expected=%0d", o, e);
            end
        end
        checks++;
        if (tcount - t0 !== 5) begin
            failures++;
            $display("FAIL rr_timeouts observed=%0d expected=5", tcount - t0);
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL rr_invariants violations=%0d expected=0", viol);
        end
    endtask

    task automatic test_handoff();
        int e;
        int o;
        exp_q.push_back(1004);
        exp_q.push_back(3001);
        req = 4'b0010;
        repeat (4) @(posedge clk);
        #2 req = 4'b1000;
        @(posedge clk);
        #2;
        checks++;
        if (gnt !== 4'b0000 || buf_en !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL handoff_turn gnt=%b buf_en=%b busy=%b, want 0000 0 1", gnt, buf_en, busy);
        end
        @(posedge clk);
        #2 req = 4'b0000;
        checks++;
        if (gnt !== 4'b1000 || owner !== 2'd3) begin
            failures++;
            $display("FAIL handoff_grant gnt=%b owner=%0d, want 1000 3", gnt, owner);
        end
        repeat (3) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL handoff_burst observed=%0d expected=%0d", o, e);
            end
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL handoff_invariants violations=%0d expected=0", viol);
        end
    endtask

    task automatic test_sole_timeout();
        int e;
        int o;
        int t0;
        do_reset();
        t0 = tcount;
        exp_q.push_back(16);
        exp_q.push_back(16);
        exp_q.push_back(6);
        req = 4'b0001;
        repeat (40) @(posedge clk);
        #2 req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL sole_burst observed=%0d expected=%0d", o, e);
            end
        end
        checks++;
        if (tcount - t0 !== 2) begin
            failures++;
            $display("FAIL sole_timeouts observed=%0d expected=2", tcount - t0);
        end
    endtask

    task automatic test_glitch();
        int e;
        int o;
        exp_q.push_back(5);
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #2 req = {3'($urandom_range(0, 7)), 1'b1};
        end
        @(posedge clk);
        #2 req = 4'b0000;
        repeat (3) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL glitch_burst observed=%0d expected=%0d", o, e);
            end
        end
        checks++;
        if (obs_q.size() !== 0) begin
            failures++;
            $display("FAIL glitch_extra_bursts observed=%0d expected=0", obs_q.size());
        end
    endtask

    task automatic test_async_reset();
        int e;
        int o;
        do_reset();
        req = 4'b0010;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || buf_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL areset_immediate gnt=%b buf_en=%b busy=%b, want 0000 0 0", gnt, buf_en, busy);
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        obs_q.delete();
        exp_q.push_back(1001);
        checks++;
        if (gnt !== 4'b0000) begin
            failures++;
            $display("FAIL areset_release gnt=%b, want 0000", gnt);
        end
        @(posedge clk);
        #2 req = 4'b0000;
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || buf_en !== 1'b1) begin
            failures++;
            $display("FAIL areset_regrant gnt=%b owner=%0d buf_en=%b, want 0010 1 1", gnt, owner, buf_en);
        end
        repeat (3) @(posedge clk);
        #2;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL areset_burst observed=%0d expected=%0d", o, e);
            end
        end
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("FAIL final_invariants violations=%0d expected=0", viol);
        end
    endtask

    initial begin
        test_reset();
        test_single_owner();
        test_round_robin();
        test_handoff();
        test_sole_timeout();
        test_glitch();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
